led_rr_arbiter: RTL and testbench
=================================

LED_RR_ARBITER -- requirements
Module: led_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 HOLD_MAX, default 16: the maximum number of cycles a grant is held when TIMEOUT_EN is defined; legal range is 2..255.
REQ-003 The ports SHALL be as follows:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req  in  8  request lines; requester i holds req[i] high while it wants the resource.
- gnt_n  out  8  active-low one-hot grant; 8'hFF means no grant.
- gnt_idx  out  3  binary index of the current owner; 0 when idle.
- gnt_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-004 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-005 All outputs SHALL be registered; gnt_n SHALL be the active-low 3-to-8 decode of gnt_idx, qualified by gnt_valid.
REQ-006 IDLE, with any req bit high at edge k: SHALL go to GRANT after edge k, owner = first set req[i] searching circularly from ptr upward (7 wraps to 0).
REQ-007 IDLE, with req == 0: SHALL stay in IDLE, gnt_n = 8'hFF, gnt_valid = 0.
REQ-008 GRANT, with req[owner] low at edge k: SHALL go to GAP after edge k; gnt_n = 8'hFF, gnt_valid = 0, ptr = owner+1 mod 8.
REQ-009 GRANT: changes on any req bit other than the owner's SHALL be ignored (no preemption).
REQ-010 GAP SHALL last exactly one cycle and then go to IDLE, so the earliest new grant is two edges after release (break-before-make).
REQ-011 Requests rising or falling during GAP SHALL have no effect until IDLE samples them.
REQ-012 If the owner releases at the same edge another requester rises, the release SHALL take priority; the new request is arbitrated from IDLE.
REQ-013 Grant latency from IDLE SHALL be one edge.
REQ-014 ptr SHALL change only on release or timeout, never on a grant.

Reset
REQ-015 While RST is high, without waiting for a clock edge, the block SHALL force: state IDLE, ptr 0, gnt_n 8'hFF, gnt_idx 0, gnt_valid 0, timeout 0, hold counter 0.
REQ-016 RST asserted mid-grant SHALL drop the grant immediately; after release, the first arbitration SHALL search from index 0.

Configuration
REQ-017 With macro LED_RR_ARBITER_TIMEOUT_EN defined:
- an 8-bit hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
- at the edge where the counter equals HOLD_MAX-1 and req[owner] is still high, the block SHALL go to GAP, advance ptr to owner+1 mod 8, and pulse timeout for one cycle (during GAP).
REQ-018 If the owner releases at the same edge the timeout would fire, the block SHALL treat it as a normal release with no timeout pulse.
REQ-019 Without the macro, no counter SHALL be synthesized, timeout SHALL be tied 0, and grants SHALL be held until release.

Structure
REQ-020 Package led_arb_pkg SHALL hold N_REQ = 8, IDX_W = 3 and the state enum (IDLE, GRANT, GAP).
REQ-021 The active-low 3-to-8 decode SHALL be one sub-module, dec3_8_n (inputs idx[2:0] and en; output y_n[7:0]; y_n = 8'hFF when en = 0).

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Single request: req = 8'h20 from IDLE -> after 1 edge gnt_n = 8'hDF, gnt_idx = 5, gnt_valid = 1; req = 0 -> after 1 edge gnt_n = 8'hFF.
- Round-robin: req = 8'hFF from reset, each owner drops its req for 1 cycle after 3 granted cycles -> grant order 0,1,...,7,0, with a one-cycle all-high gap between grants.
- Wrap-around: after owner 6 releases (ptr = 7), req = 8'h09 -> grant to 0, then (ptr = 1) to 3.
- Same-edge events: owner 2 drops req[2] at the edge req[4] rises -> GAP, then grant to 4 two edges after the release.
- Timeout: TIMEOUT_EN defined, HOLD_MAX = 4, req = 8'h04 held -> gnt_n = 8'hFB for 4 cycles, then timeout = 1 with gnt_n = 8'hFF, then re-grant to 2.
- Reset mid-grant: RST pulsed asynchronously while owner = 3 -> gnt_n = 8'hFF before the next edge; with req = 8'h88 after release -> grant to 3 (search from 0).

Source files
------------

// File: rtl/led_rr_arbiter_pkg.sv
// Shared constants, state encoding and round-robin search helper for the LED arbiter.
package led_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // First set request at or after ptr, wrapping 7 -> 0; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface led_rr_arbiter_if;
  import led_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt_n;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    input  req,
    output gnt_n,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

  modport slave (
    output req,
    input  gnt_n,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

endinterface

// File: rtl/led_rr_arbiter_dec3_8_n.sv
// Active-low 3-to-8 decoder; all outputs high when en is low.
module dec3_8_n
  import led_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y_n
);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign y_n[gi] = ~(en && (idx == IDX_W'(gi)));
    end
  endgenerate

endmodule

// File: rtl/led_rr_arbiter.sv
// Eight-way round-robin arbiter with break-before-make gap and registered outputs.
// Optional hold-time limit enabled by defining LED_RR_ARBITER_TIMEOUT_EN.
module led_rr_arbiter
  import led_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  led_rr_arbiter_if.master    bus
);

  generate
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
      $error("HOLD_MAX must be in 2..255");
    end
  endgenerate

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
  logic             gnt_valid_reg, gnt_valid_next;
  logic [N_REQ-1:0] gnt_n_reg, gnt_n_next;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;

  assign pick_idx  = rr_pick(bus.req, ptr_reg);
  assign owner_req = bus.req[gnt_idx_reg];

`ifdef LED_RR_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic       timeout_reg, timeout_next;
`endif

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
`ifdef LED_RR_ARBITER_TIMEOUT_EN
    hold_cnt_next  = hold_cnt_reg;
    timeout_next   = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          state_next     = GRANT;
          gnt_idx_next   = pick_idx;
          gnt_valid_next = 1'b1;
`ifdef LED_RR_ARBITER_TIMEOUT_EN
          hold_cnt_next  = '0;
`endif
        end else begin
          gnt_idx_next   = '0;
          gnt_valid_next = 1'b0;
        end
      end
      GRANT: begin
        // Release wins over a same-edge timeout.
        if (!owner_req) begin
          state_next     = GAP;
          ptr_next       = gnt_idx_reg + 3'd1;
          gnt_idx_next   = '0;
          gnt_valid_next = 1'b0;
        end
`ifdef LED_RR_ARBITER_TIMEOUT_EN
        else if (hold_cnt_reg == HOLD_LAST) begin
          state_next     = GAP;
          ptr_next       = gnt_idx_reg + 3'd1;
          gnt_idx_next   = '0;
          gnt_valid_next = 1'b0;
          timeout_next   = 1'b1;
        end else begin
          hold_cnt_next  = hold_cnt_reg + 8'd1;
        end
`endif
      end
      GAP: begin
        state_next     = IDLE;
        gnt_idx_next   = '0;
        gnt_valid_next = 1'b0;
      end
      default: begin
        state_next     = IDLE;
        gnt_idx_next   = '0;
        gnt_valid_next = 1'b0;
      end
    endcase
  end

  dec3_8_n u_dec (
    .idx (gnt_idx_next),
    .en  (gnt_valid_next),
    .y_n (gnt_n_next)
  );

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      gnt_n_reg     <= '1;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
      gnt_n_reg     <= gnt_n_next;
    end
  end

`ifdef LED_RR_ARBITER_TIMEOUT_EN
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.timeout = timeout_reg;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt_n     = gnt_n_reg;
  assign bus.gnt_idx   = gnt_idx_reg;
  assign bus.gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_led_rr_arbiter.sv
// Bench for led_rr_arbiter: directed scenarios plus random requests against a cycle model.
module tb_led_rr_arbiter;
  import led_arb_pkg::*;

  localparam int HOLD = 4;
`ifdef LED_RR_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic RST;
  led_rr_arbiter_if bus ();

  led_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  // Model: owner -1 means nobody holds the resource; held counts granted cycles so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_gap   = 1'b0;
  bit m_to    = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_n;
    exp_n = (m_owner < 0) ? 8'hFF : ~(8'h01 << m_owner);
    check({tag, "/gnt_n"}, bus.gnt_n, exp_n);
    check({tag, "/gnt_idx"}, 8'(bus.gnt_idx), 8'((m_owner < 0) ? 0 : m_owner));
    check({tag, "/gnt_valid"}, 8'(bus.gnt_valid), 8'(m_owner >= 0));
    check({tag, "/timeout"}, 8'(bus.timeout), 8'(m_to));
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] v);
    bit found;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!v[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_gap   = 1'b1;
      end else if (TO_EN && m_held == HOLD) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_gap   = 1'b1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (v != 8'h00) begin
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!found && v[(m_ptr + i) % 8]) begin
          m_owner = (m_ptr + i) % 8;
          found   = 1'b1;
        end
      end
      m_held = 1;
    end
  endtask

  task automatic tick(input logic [7:0] v, input string tag);
    bus.req = v;
    @(posedge CLOCK_50);
    model_edge(v);
    #1;
    check_all(tag);
    $display("t=%0t %s req=%h gnt_n=%h idx=%0d valid=%0b to=%0b",
             $time, tag, v, bus.gnt_n, bus.gnt_idx, bus.gnt_valid, bus.timeout);
  endtask

  // Called just after an edge: asserts RST mid-cycle and checks outputs before the next edge.
  task automatic pulse_reset(input string tag);
    #3;
    RST = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    $display("t=%0t %s async reset gnt_n=%h", $time, tag, bus.gnt_n);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int r;
    RST     = 1'b1;
    bus.req = 8'h00;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_all("reset");
    RST = 1'b0;

    // Single request
    tick(8'h20, "single");
    check("single/gnt_n_lit", bus.gnt_n, 8'hDF);
    check("single/idx_lit", 8'(bus.gnt_idx), 8'd5);
    tick(8'h00, "single_rel");
    check("single_rel/gnt_n_lit", bus.gnt_n, 8'hFF);
    tick(8'h00, "idle");
    tick(8'h00, "idle");

    // Round-robin order 0..7,0 from reset
    pulse_reset("rr_reset");
    tick(8'hFF, "rr");
    for (int k = 0; k < 9; k++) begin
      check("rr/order", 8'(bus.gnt_idx), 8'(k % 8));
      tick(8'hFF, "rr_hold");
      tick(8'hFF, "rr_hold");
      tick(8'hFF & ~(8'h01 << (k % 8)), "rr_drop");
      check("rr/gap", bus.gnt_n, 8'hFF);
      tick(8'hFF, "rr_idle");
      tick(8'hFF, "rr_grant");
    end
    tick(8'h00, "rr_end");
    tick(8'h00, "rr_end");
    tick(8'h00, "rr_end");

    // Wrap-around
    pulse_reset("wrap_reset");
    tick(8'h40, "wrap_g6");
    tick(8'h00, "wrap_rel6");
    tick(8'h09, "wrap_gap");
    tick(8'h09, "wrap_g0");
    check("wrap/idx0", 8'(bus.gnt_idx), 8'd0);
    tick(8'h08, "wrap_rel0");
    tick(8'h08, "wrap_gap");
    tick(8'h08, "wrap_g3");
    check("wrap/idx3", 8'(bus.gnt_idx), 8'd3);
    tick(8'h00, "wrap_end");
    tick(8'h00, "wrap_end");

    // Same-edge release and new request
    pulse_reset("same_reset");
    tick(8'h04, "same_g2");
    tick(8'h04, "same_hold");
    tick(8'h10, "same_rel");
    check("same/gap", bus.gnt_n, 8'hFF);
    tick(8'h10, "same_idle");
    check("same/still_gap", bus.gnt_n, 8'hFF);
    tick(8'h10, "same_g4");
    check("same/g4", bus.gnt_n, 8'hEF);
    tick(8'h00, "same_end");
    tick(8'h00, "same_end");

`ifdef LED_RR_ARBITER_TIMEOUT_EN
    // Timeout after HOLD cycles
    pulse_reset("to_reset");
    for (int c = 0; c < HOLD; c++) begin
      tick(8'h04, "to_hold");
      check("to/held", bus.gnt_n, 8'hFB);
    end
    tick(8'h04, "to_fire");
    check("to/pulse", 8'(bus.timeout), 8'd1);
    check("to/gnt_n", bus.gnt_n, 8'hFF);
    tick(8'h04, "to_gap");
    tick(8'h04, "to_regrant");
    check("to/regrant", bus.gnt_n, 8'hFB);
    tick(8'h00, "to_end");
    tick(8'h00, "to_end");
`endif

    // Reset mid-grant
    tick(8'h08, "rst_g3");
    tick(8'h08, "rst_hold");
    pulse_reset("rst_mid");
    check("rst_mid/gnt_n", bus.gnt_n, 8'hFF);
    tick(8'h88, "rst_g3_again");
    check("rst_mid/idx3", 8'(bus.gnt_idx), 8'd3);
    tick(8'h00, "rst_end");

    // Random traffic
    v = 8'h00;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r >= 6 && r < 9) v = 8'($urandom_range(0, 255));
      else if (r == 9) v = v ^ (8'h01 << $urandom_range(0, 7));
      tick(v, "rand");
      if ($urandom_range(0, 96) == 0) pulse_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
